// File: rtl/multi_bit_cycropuf_crp_ctrl.sv
// Challenge-response controller for a multi-bit CycRO PUF: reset, settle, sample, majority vote.
// Optional CYCROPUF_STABILITY_MASK_EN builds the per-bit capture-disagreement flags on rsp_unstable.
module multi_bit_cycropuf_crp_ctrl #(
    parameter int WIDTH         = 6,
    parameter int NUM_SAMPLES   = 7,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_chal,
    output logic [WIDTH-1:0] puf_chal,
    output logic             puf_enable,
    output logic             puf_reset,
    input  logic [WIDTH-1:0] puf_resp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_chal,
    output logic [WIDTH-1:0] rsp_unstable
);

    localparam int unsigned W    = WIDTH;
    localparam int          OW   = $clog2(NUM_SAMPLES + 1);
    localparam int          CMAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int          CLIM = (CMAX > 2) ? CMAX : 2;
    localparam int          CW   = (CLIM > 2) ? $clog2(CLIM) : 1;

    localparam logic [OW-1:0] HALF = OW'(NUM_SAMPLES / 2);

    typedef enum logic [2:0] {
        IDLE,
        PUF_RST,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            capture;
    logic [OW-1:0]   ones [W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        puf_enable = 1'b0;
        puf_reset  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = PUF_RST;
                end
            end
            PUF_RST: begin
                puf_reset = 1'b1;
                if (cnt == CW'(1)) state_nxt = SETTLE;
            end
            SETTLE: begin
                puf_enable = 1'b1;
                if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                puf_enable = 1'b1;
                capture    = 1'b1;
                if (cnt == CW'(NUM_SAMPLES - 1)) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Hold the PUF in reset for as long as the controller itself is in reset.
        if (!reset) puf_reset = 1'b1;
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == PUF_RST || state == SETTLE || state == SAMPLE) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            puf_chal <= '0;
            for (int unsigned b = 0; b < W; b++) ones[b] <= '0;
        end else begin
            if (accept) puf_chal <= req_chal;
            if (state == PUF_RST) begin
                for (int unsigned b = 0; b < W; b++) ones[b] <= '0;
            end else if (capture) begin
                for (int unsigned b = 0; b < W; b++) ones[b] <= ones[b] + OW'(puf_resp[b]);
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int unsigned b = 0; b < W; b++) rsp_data[b] = (ones[b] > HALF);
    end

    assign rsp_chal = puf_chal;

`ifdef CYCROPUF_STABILITY_MASK_EN
    localparam logic [OW-1:0] NSAMP = OW'(NUM_SAMPLES);

    always_comb begin
        rsp_unstable = '0;
        for (int unsigned b = 0; b < W; b++) rsp_unstable[b] = (ones[b] != '0) && (ones[b] < NSAMP);
    end
`else
    assign rsp_unstable = '0;
`endif

endmodule
